// File: rtl/lcd_reader_if.sv
// Signal bundle between the LCD read engine, its requester and the LCD pin mux.
// The slave modport is the reader itself; master is the requester/pad side.
`timescale 1ns/1ps
interface lcd_reader_if;
  logic       req;
  logic       req_rs;
  logic       req_poll;
  logic       bus_req;
  logic       bus_gnt;
  logic [7:0] lcd_data_in;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       busy;
  logic       done;
  logic       aborted;
  logic       timeout;
  logic [7:0] rd_data;
  logic       bf;
  logic [6:0] ac;

  modport slave (
    input  req, req_rs, req_poll, bus_gnt, lcd_data_in,
    output bus_req, LCD_E, LCD_RS, LCD_RW, busy, done, aborted, timeout,
           rd_data, bf, ac
  );

  modport master (
    output req, req_rs, req_poll, bus_gnt, lcd_data_in,
    input  bus_req, LCD_E, LCD_RS, LCD_RW, busy, done, aborted, timeout,
           rd_data, bf, ac
  );
endinterface

// File: rtl/lcd_reader.sv
// HD44780 read engine: arbitrated busy-flag/address and data reads with optional BF polling.
// Optional macro LCD_READER_TIMEOUT_EN bounds polling at MAX_POLLS reads.
`timescale 1ns/1ps
module lcd_reader #(
  parameter int T_AS      = 2,
  parameter int T_EH      = 25,
  parameter int T_EL      = 25,
  parameter int MAX_POLLS = 1000
) (
  input logic        clk,
  input logic        rst,
  lcd_reader_if.slave bus
);

  localparam int CNT_A   = (T_AS > T_EH) ? T_AS : T_EH;
  localparam int CNT_B   = (T_EL > MAX_POLLS) ? T_EL : MAX_POLLS;
  localparam int CNT_MAX = (CNT_A > CNT_B) ? CNT_A : CNT_B;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] AS_LAST = CW'(T_AS - 1);
  localparam logic [CW-1:0] EH_LAST = CW'(T_EH - 1);
  localparam logic [CW-1:0] EL_LAST = CW'(T_EL - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_SETUP, S_EHIGH, S_ELOW, S_CHECK, S_DONE
  } state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic            w_capture, w_abort, w_timeout, w_sample_set, w_own, w_timed;
  logic            r_cap_rs, r_poll, r_sample;
  logic            r_bus_req, r_lcd_e, r_lcd_rs, r_lcd_rw;
  logic            r_busy, r_done, r_aborted, r_timeout;
  logic [7:0]      r_rd_data;
  logic            r_bf;
  logic [6:0]      r_ac;
`ifdef LCD_READER_TIMEOUT_EN
  localparam logic [CW-1:0] POLL_LAST = CW'(MAX_POLLS - 1);
  logic [CW-1:0]   r_polls;
  logic            w_poll_inc;
`endif

  // Next-state and phase-counter logic
  always_comb begin
    w_next       = r_state;
    w_capture    = 1'b0;
    w_abort      = 1'b0;
    w_timeout    = 1'b0;
    w_sample_set = 1'b0;
`ifdef LCD_READER_TIMEOUT_EN
    w_poll_inc   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        // busy still high means the done cycle is showing; requests then are dropped
        if (bus.req && !r_busy) begin
          w_capture = 1'b1;
          w_next    = S_ARB;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ARB: begin
        if (bus.bus_gnt) w_next = S_SETUP;
        else             w_next = S_ARB;
      end
      S_SETUP: begin
        if (!bus.bus_gnt) begin
          w_next  = S_DONE;
          w_abort = 1'b1;
        end else if (r_cnt == AS_LAST) begin
          w_next = S_EHIGH;
        end else begin
          w_next = S_SETUP;
        end
      end
      S_EHIGH: begin
        if (!bus.bus_gnt) begin
          w_next  = S_DONE;
          w_abort = 1'b1;
        end else if (r_cnt == EH_LAST) begin
          w_next       = S_ELOW;
          w_sample_set = 1'b1;
        end else begin
          w_next = S_EHIGH;
        end
      end
      S_ELOW: begin
        if (!bus.bus_gnt) begin
          w_next  = S_DONE;
          w_abort = 1'b1;
        end else if (r_cnt == EL_LAST) begin
          w_next = S_CHECK;
        end else begin
          w_next = S_ELOW;
        end
      end
      S_CHECK: begin
        if (!bus.bus_gnt) begin
          w_next  = S_DONE;
          w_abort = 1'b1;
        end else if (r_poll && r_bf) begin
`ifdef LCD_READER_TIMEOUT_EN
          if (r_polls == POLL_LAST) begin
            w_next    = S_DONE;
            w_timeout = 1'b1;
          end else begin
            w_next     = S_SETUP;
            w_poll_inc = 1'b1;
          end
`else
          w_next = S_SETUP;
`endif
        end else begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase

    w_timed = (r_state == S_SETUP) || (r_state == S_EHIGH) || (r_state == S_ELOW);
    w_own   = w_capture || (r_state == S_ARB) || w_timed || (r_state == S_CHECK);
    if (w_timed && (w_next == r_state)) w_cnt_next = r_cnt + 1'b1;
    else                                w_cnt_next = {CW{1'b0}};
  end

  // State and phase counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= {CW{1'b0}};
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Captured request attributes and poll counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_rs <= 1'b0;
      r_poll   <= 1'b0;
`ifdef LCD_READER_TIMEOUT_EN
      r_polls  <= {CW{1'b0}};
`endif
    end else if (w_capture) begin
      r_cap_rs <= bus.req_rs;
      r_poll   <= bus.req_poll & ~bus.req_rs;
`ifdef LCD_READER_TIMEOUT_EN
      r_polls  <= {CW{1'b0}};
    end else if (w_poll_inc) begin
      r_polls  <= r_polls + 1'b1;
`endif
    end
  end

  // Pin and status registers, one cycle behind the state they reflect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus_req <= 1'b0;
      r_lcd_rw  <= 1'b0;
      r_lcd_rs  <= 1'b0;
      r_lcd_e   <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_aborted <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_bus_req <= w_own;
      r_lcd_rw  <= w_own;
      r_lcd_e   <= (r_state == S_EHIGH) && bus.bus_gnt;
      r_done    <= (r_state == S_DONE);
      if (w_capture)  r_lcd_rs <= bus.req_rs;
      else if (w_own) r_lcd_rs <= r_cap_rs;
      else            r_lcd_rs <= 1'b0;
      if (w_capture)   r_busy <= 1'b1;
      else if (r_done) r_busy <= 1'b0;
      if (w_capture)    r_aborted <= 1'b0;
      else if (w_abort) r_aborted <= 1'b1;
      if (w_capture)      r_timeout <= 1'b0;
      else if (w_timeout) r_timeout <= 1'b1;
    end
  end

  // Data capture on the edge that ends the final E-high cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample  <= 1'b0;
      r_rd_data <= 8'h00;
      r_bf      <= 1'b0;
      r_ac      <= 7'h00;
    end else begin
      r_sample <= w_sample_set;
      if (r_sample) begin
        r_rd_data <= bus.lcd_data_in;
        if (!r_cap_rs) begin
          r_bf <= bus.lcd_data_in[7];
          r_ac <= bus.lcd_data_in[6:0];
        end
      end
    end
  end

  assign bus.bus_req = r_bus_req;
  assign bus.LCD_E   = r_lcd_e;
  assign bus.LCD_RS  = r_lcd_rs;
  assign bus.LCD_RW  = r_lcd_rw;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.aborted = r_aborted;
  assign bus.timeout = r_timeout;
  assign bus.rd_data = r_rd_data;
  assign bus.bf      = r_bf;
  assign bus.ac      = r_ac;

endmodule

// File: doc/lcd_reader.md
Name: lcd_reader

Overview:
- Read-side engine for the HD44780-style character LCD bus. The existing LCD block only writes to this bus.
- Performs timed read cycles with RW=1:
  - busy-flag/address-counter read (RS=0)
  - DDRAM/CGRAM data read (RS=1)
- Optionally polls the busy flag until it clears.
- Shares LCD_E/RS/RW with the LCD write engine through a bus_req/bus_gnt arbitration handshake. The top-level mux routes pins to whichever engine holds the grant.

Parameters:
T_AS, 2, cycles RS/RW stable before E rises (min 1)
T_EH, 25, cycles E held high; data sampled on the last of these (min 1)
T_EL, 25, cycles E held low after the fall before the next action (min 1)
MAX_POLLS, 1000, busy-flag reads before timeout (used only with LCD_READER_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
req  input  1  start request; sampled only in IDLE
req_rs  input  1  0 = busy/address read, 1 = data read; captured with req
req_poll  input  1  1 = repeat busy reads until BF=0; valid only when req_rs=0
bus_req  output  1  request for ownership of the LCD pins
bus_gnt  input  1  ownership granted by the LCD pin mux
lcd_data_in  input  8  LCD_DATA as seen at the pad (LCD drives it while RW=1)
LCD_E  output  1  enable strobe
LCD_RS  output  1  register select
LCD_RW  output  1  read/write; 1 during a transaction
busy  output  1  high from the req capture until the cycle after done
done  output  1  one-cycle completion pulse
aborted  output  1  qualifies done: grant was lost mid-transaction
timeout  output  1  qualifies done: polling limit reached
rd_data  output  8  last sampled byte
bf  output  1  rd_data[7] of the last RS=0 read
ac  output  7  rd_data[6:0] of the last RS=0 read

Behaviour:
- Reset (async, active-high): all of the following go to 0 immediately, including mid-transaction:
  - state to IDLE
  - LCD_E, LCD_RS, LCD_RW, bus_req, busy, done, aborted, timeout, rd_data, bf, ac, all counters
- States: IDLE, ARB, SETUP, EHIGH, ELOW, CHECK, DONE.
- IDLE:
  - On req=1: capture req_rs, and req_poll & ~req_rs. Go to ARB and set busy and bus_req.
  - req in any other state is ignored.
- ARB:
  - Hold bus_req. When bus_gnt=1, go to SETUP.
  - LCD_RW=1, LCD_RS=captured rs, LCD_E=0.
- SETUP: T_AS cycles, E=0, then EHIGH.
- EHIGH:
  - T_EH cycles, E=1.
  - On the last cycle, register lcd_data_in into rd_data.
  - If rs=0, also update bf and ac.
  - Then go to ELOW.
- ELOW: T_EL cycles, E=0, then CHECK.
- CHECK (1 cycle):
  - If poll and bf=1 (and limit not reached): go to SETUP and increment the poll counter.
  - Otherwise: go to DONE.
- DONE (1 cycle):
  - done=1, bus_req=0, LCD_RW=0, then IDLE.
  - busy clears on entering IDLE.
  - aborted and timeout are valid with done and hold until the next req capture.
- Latency, single read with gnt already high:
  - req sampled at edge n; done high in the cycle after edge n+3+T_AS+T_EH+T_EL.
  - Defaults: n+55.
  - Each extra poll iteration adds T_AS+T_EH+T_EL+1 cycles.
- Grant loss: if bus_gnt falls in SETUP, EHIGH, ELOW or CHECK:
  - Next cycle: E=0 and go to DONE with aborted=1.
  - rd_data and bf/ac are not updated unless the EHIGH sample edge already occurred.
- Counters: sized to hold the maximum of T_AS, T_EH, T_EL and MAX_POLLS. No wrap occurs inside a phase.
- Outputs are registered. No combinational path from inputs to LCD pins.

Optional Feature:
- Macro LCD_READER_TIMEOUT_EN.
- Defined:
  - Poll counter compares against MAX_POLLS.
  - When MAX_POLLS reads have all returned bf=1, CHECK goes to DONE with timeout=1.
  - A single non-poll read never times out.
- Undefined:
  - Polling is unbounded and the poll counter is omitted.
  - timeout is tied 0.

Test Plan:
- Reset mid-EHIGH (E=1) -> E, RW, bus_req and busy are 0 immediately; state is IDLE.
- req=1, req_rs=1, bus_gnt tied 1, lcd_data_in=8'h41 -> RS=1, RW=1, E high for 25 cycles; done at n+55; rd_data=41; bf and ac unchanged.
- req_rs=0, req_poll=1, lcd_data_in=8'h85 for 3 reads, then 8'h05 -> 4 E pulses; done with bf=0, ac=7'h05, timeout=0.
- Same as the poll case with bf held 1, MAX_POLLS=4, LCD_READER_TIMEOUT_EN defined -> exactly 4 E pulses, then done with timeout=1.
- bus_gnt held 0 for 10 cycles after req -> bus_req stays high and E stays low. After gnt rises, the normal cycle completes. Dropping gnt during ELOW -> done with aborted=1.
- req pulsed again while busy and during DONE -> ignored; no second transaction occurs.
